// File: rtl/cnn_param_loader.sv
// Host-side loader: packs a byte stream into feature, FC and bias write strobes for the CNN core,
// then starts the core, waits a fixed run time and captures its output.
module cnn_param_loader #(
  parameter int KERNEL_SIZE      = 4,
  parameter int NUM_FEATURES     = 3,
  parameter int FLATTENED_LENGTH = 432,
  parameter int FC_CHUNK         = 16,
  parameter int DATA_WIDTH       = 8,
  parameter int BIAS_DATA_WIDTH  = 32,
  parameter int RUN_CYCLES       = 640
) (
  input  logic                                                   clk,
  input  logic                                                   rst_cnn,
  input  logic                                                   load_start,
  input  logic                                                   s_valid,
  input  logic        [DATA_WIDTH-1:0]                           s_data,
  output logic                                                   s_ready,
  output logic signed [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   feature_weights_input,
  output logic        [$clog2(NUM_FEATURES+1)-1:0]               feature_writeAddr,
  output logic                                                   feature_WrEn,
  output logic signed [FC_CHUNK*DATA_WIDTH-1:0]                  fullyconnected_weights_input,
  output logic        [$clog2(FLATTENED_LENGTH/FC_CHUNK)-1:0]    fullyconnected_writeAddr,
  output logic                                                   fullyconnected_WrEn,
  output logic signed [(NUM_FEATURES+1)*BIAS_DATA_WIDTH-1:0]     bias_weights_input,
  output logic                                                   bias_WrEn,
  output logic                                                   convolution_enable,
  input  logic        [DATA_WIDTH-1:0]                           cnn_output,
  output logic        [DATA_WIDTH-1:0]                           result,
  output logic                                                   result_valid,
  output logic                                                   busy
);

  localparam int FEAT_BYTES = KERNEL_SIZE * KERNEL_SIZE;
  localparam int FC_CHUNKS  = FLATTENED_LENGTH / FC_CHUNK;
  localparam int BIAS_BYTES = (NUM_FEATURES + 1) * BIAS_DATA_WIDTH / DATA_WIDTH;
  localparam int BUF_N0     = (FEAT_BYTES > FC_CHUNK) ? FEAT_BYTES : FC_CHUNK;
  localparam int BUF_N      = (BUF_N0 > BIAS_BYTES) ? BUF_N0 : BIAS_BYTES;
  localparam int CNT_W      = $clog2(BUF_N);
  localparam int FEAT_AW    = $clog2(NUM_FEATURES + 1);
  localparam int FC_AW      = $clog2(FC_CHUNKS);
  localparam int RUN_W      = $clog2(RUN_CYCLES);

  typedef enum logic [3:0] {
    IDLE, LOAD_FEAT, WR_FEAT, LOAD_FC, WR_FC, LOAD_BIAS, WR_BIAS, START, RUN, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        byte_cnt;
  logic [FEAT_AW-1:0]      feat_idx;
  logic [FC_AW-1:0]        chunk_idx;
  logic [RUN_W-1:0]        run_cnt;
  logic [DATA_WIDTH-1:0]   byte_buf [BUF_N];
  logic                    last_byte;
  logic                    take;
  logic                    run_done;

  assign take     = s_valid & s_ready;
  assign run_done = (run_cnt == RUN_W'(RUN_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_cnn) begin
    if (!rst_cnn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    s_ready             = 1'b0;
    busy                = 1'b1;
    last_byte           = 1'b0;
    feature_WrEn        = 1'b1;
    fullyconnected_WrEn = 1'b1;
    bias_WrEn           = 1'b1;
    convolution_enable  = 1'b1;
    result_valid        = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (load_start) state_d = LOAD_FEAT;
      end
      LOAD_FEAT: begin
        s_ready   = 1'b1;
        last_byte = (byte_cnt == CNT_W'(FEAT_BYTES - 1));
        if (take && last_byte) state_d = WR_FEAT;
      end
      WR_FEAT: begin
        feature_WrEn = 1'b0;
        state_d = (feat_idx == FEAT_AW'(NUM_FEATURES - 1)) ? LOAD_FC : LOAD_FEAT;
      end
      LOAD_FC: begin
        s_ready   = 1'b1;
        last_byte = (byte_cnt == CNT_W'(FC_CHUNK - 1));
        if (take && last_byte) state_d = WR_FC;
      end
      WR_FC: begin
        fullyconnected_WrEn = 1'b0;
        state_d = (chunk_idx == FC_AW'(FC_CHUNKS - 1)) ? LOAD_BIAS : LOAD_FC;
      end
      LOAD_BIAS: begin
        s_ready   = 1'b1;
        last_byte = (byte_cnt == CNT_W'(BIAS_BYTES - 1));
        if (take && last_byte) state_d = WR_BIAS;
      end
      WR_BIAS: begin
        bias_WrEn = 1'b0;
        state_d   = START;
      end
      START: begin
        convolution_enable = 1'b0;
        state_d            = RUN;
      end
      RUN: if (run_done) state_d = DONE;
      DONE: begin
        result_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Staging buffer holds all but the final byte of a chunk; that byte is taken straight from s_data.
  always_ff @(posedge clk) begin
    if (take) byte_buf[byte_cnt] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_cnn) begin
    if (!rst_cnn) begin
      byte_cnt                     <= '0;
      feat_idx                     <= '0;
      chunk_idx                    <= '0;
      run_cnt                      <= '0;
      feature_weights_input        <= '0;
      feature_writeAddr            <= '0;
      fullyconnected_weights_input <= '0;
      fullyconnected_writeAddr     <= '0;
      bias_weights_input           <= '0;
      result                       <= '0;
    end else begin
      if (state_q == IDLE) begin
        byte_cnt  <= '0;
        feat_idx  <= '0;
        chunk_idx <= '0;
      end
      if (take) byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
      if (take && last_byte) begin
        case (state_q)
          LOAD_FEAT: begin
            for (int k = 0; k < FEAT_BYTES - 1; k++)
              feature_weights_input[k*DATA_WIDTH +: DATA_WIDTH] <= byte_buf[k];
            feature_weights_input[(FEAT_BYTES-1)*DATA_WIDTH +: DATA_WIDTH] <= s_data;
            feature_writeAddr <= feat_idx;
          end
          LOAD_FC: begin
            for (int k = 0; k < FC_CHUNK - 1; k++)
              fullyconnected_weights_input[k*DATA_WIDTH +: DATA_WIDTH] <= byte_buf[k];
            fullyconnected_weights_input[(FC_CHUNK-1)*DATA_WIDTH +: DATA_WIDTH] <= s_data;
            fullyconnected_writeAddr <= chunk_idx;
          end
          LOAD_BIAS: begin
            // Little-endian bias bytes laid end to end form the concatenated bias words directly.
            for (int k = 0; k < BIAS_BYTES - 1; k++)
              bias_weights_input[k*DATA_WIDTH +: DATA_WIDTH] <= byte_buf[k];
            bias_weights_input[(BIAS_BYTES-1)*DATA_WIDTH +: DATA_WIDTH] <= s_data;
          end
          default: ;
        endcase
      end
      if (state_q == WR_FEAT) feat_idx  <= feat_idx + 1'b1;
      if (state_q == WR_FC)   chunk_idx <= chunk_idx + 1'b1;
      if (state_q == START)    run_cnt <= '0;
      else if (state_q == RUN) run_cnt <= run_cnt + 1'b1;
      if (state_q == RUN && run_done) result <= cnn_output;
    end
  end

endmodule

// File: tb/tb_cnn_param_loader.sv
// Scenario bench for cnn_param_loader: streams weight images, records every write strobe and
// compares the packed contents, ordering and timing against an index-based model of the stream.
module tb_cnn_param_loader;

  localparam int KS = 4, NF = 3, FL = 432, FCC = 16, DW = 8, BW = 32, RUN = 640;
  localparam int FEAT_B    = KS * KS;
  localparam int FC_N      = FL / FCC;
  localparam int NBIAS     = NF + 1;
  localparam int FC_BASE   = NF * FEAT_B;
  localparam int BIAS_BASE = FC_BASE + FL;
  localparam int TOTAL     = BIAS_BASE + NBIAS * BW / 8;

  logic clk = 1'b0, rst_cnn = 1'b0, load_start = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = 8'h00, cnn_output = 8'h00;
  logic s_ready, feature_WrEn, fullyconnected_WrEn, bias_WrEn, convolution_enable;
  logic result_valid, busy;
  logic signed [FEAT_B*DW-1:0] feature_weights_input;
  logic signed [FCC*DW-1:0]    fullyconnected_weights_input;
  logic signed [NBIAS*BW-1:0]  bias_weights_input;
  logic [1:0] feature_writeAddr;
  logic [4:0] fullyconnected_writeAddr;
  logic [7:0] result;

  cnn_param_loader #(
    .KERNEL_SIZE(KS), .NUM_FEATURES(NF), .FLATTENED_LENGTH(FL), .FC_CHUNK(FCC),
    .DATA_WIDTH(DW), .BIAS_DATA_WIDTH(BW), .RUN_CYCLES(RUN)
  ) dut (
    .clk(clk), .rst_cnn(rst_cnn), .load_start(load_start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .feature_weights_input(feature_weights_input),
    .feature_writeAddr(feature_writeAddr), .feature_WrEn(feature_WrEn),
    .fullyconnected_weights_input(fullyconnected_weights_input),
    .fullyconnected_writeAddr(fullyconnected_writeAddr), .fullyconnected_WrEn(fullyconnected_WrEn),
    .bias_weights_input(bias_weights_input), .bias_WrEn(bias_WrEn),
    .convolution_enable(convolution_enable), .cnn_output(cnn_output), .result(result),
    .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  logic [7:0] stream [TOTAL];
  bit abort = 1'b0;

  // Event recorder: every strobe, handshake and flag edge, with cycle offsets from load_start.
  int cyc = 0, start_cyc = 0, strobe_viol = 0;
  logic prev_low = 1'b0, prev_busy = 1'b0;
  logic [FEAT_B*DW-1:0] fw_data_q [$];
  int                   fw_addr_q [$];
  int                   fw_cyc_q  [$];
  logic [FCC*DW-1:0]    fc_data_q [$];
  int                   fc_addr_q [$];
  logic [NBIAS*BW-1:0]  bias_q    [$];
  int                   conv_q    [$];
  int                   rv_q      [$];
  logic [7:0]           rv_val_q  [$];
  int                   busy_fall_q [$];
  logic [7:0]           acc_q     [$];

  logic any_low, multi_low;
  assign any_low   = !feature_WrEn || !fullyconnected_WrEn || !bias_WrEn;
  assign multi_low = (!feature_WrEn && !fullyconnected_WrEn) || (!feature_WrEn && !bias_WrEn) ||
                     (!fullyconnected_WrEn && !bias_WrEn);

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_cnn && load_start && !busy) start_cyc <= cyc;
    if (!feature_WrEn) begin
      fw_data_q.push_back(feature_weights_input);
      fw_addr_q.push_back(int'(feature_writeAddr));
      fw_cyc_q.push_back(cyc - start_cyc);
    end
    if (!fullyconnected_WrEn) begin
      fc_data_q.push_back(fullyconnected_weights_input);
      fc_addr_q.push_back(int'(fullyconnected_writeAddr));
    end
    if (!bias_WrEn) bias_q.push_back(bias_weights_input);
    if (!convolution_enable) conv_q.push_back(cyc - start_cyc);
    if (result_valid) begin
      rv_q.push_back(cyc - start_cyc);
      rv_val_q.push_back(result);
    end
    if (prev_busy && !busy) busy_fall_q.push_back(cyc - start_cyc);
    if (s_valid && s_ready) acc_q.push_back(s_data);
    if (multi_low || (any_low && prev_low) || (any_low && s_ready)) strobe_viol <= strobe_viol + 1;
    prev_low  <= any_low;
    prev_busy <= busy;
  end

  // Reference: feature f weight k = stream[f*16+k]; FC chunk c weight k = stream[48+16c+k];
  // bias b = little-endian word from stream[480+4b .. 483+4b]. Returns number of disagreements.
  function automatic int load_errors(int fo, int co, int bo);
    int e = 0;
    logic [FEAT_B*DW-1:0] fd;
    logic [FCC*DW-1:0]    cd;
    logic [NBIAS*BW-1:0]  bd;
    logic [BW-1:0]        w;
    if (fw_data_q.size() != fo + NF || fc_data_q.size() != co + FC_N || bias_q.size() != bo + 1)
      return 1000;
    for (int f = 0; f < NF; f++) begin
      fd = fw_data_q[fo+f];
      if (fw_addr_q[fo+f] != f) e++;
      for (int k = 0; k < FEAT_B; k++) if (fd[k*DW +: DW] !== stream[f*FEAT_B+k]) e++;
    end
    for (int c = 0; c < FC_N; c++) begin
      cd = fc_data_q[co+c];
      if (fc_addr_q[co+c] != c) e++;
      for (int k = 0; k < FCC; k++) if (cd[k*DW +: DW] !== stream[FC_BASE+c*FCC+k]) e++;
    end
    bd = bias_q[bo];
    for (int b = 0; b < NBIAS; b++) begin
      w = '0;
      for (int j = BW/8 - 1; j >= 0; j--) w = {w[BW-9:0], stream[BIAS_BASE + b*(BW/8) + j]};
      if (bd[b*BW +: BW] !== w) e++;
    end
    return e;
  endfunction

  task automatic drive_stream(input int mode);
    int idx = 0, guard = 0;
    bit hs, tog = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b1;
    while (idx < TOTAL && !abort && guard < 20000) begin
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = tog;
        default: s_valid = ($urandom_range(0, 3) != 0);
      endcase
      tog    = !tog;
      s_data = stream[idx];
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      load_start = 1'b0;
      if (hs) idx++;
      guard++;
    end
    s_valid    = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic wait_result(input int rv0, output bit to);
    for (int i = 0; i < 3000 && rv_q.size() <= rv0; i++) @(negedge clk);
    to = (rv_q.size() <= rv0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_cnn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({s_ready, busy, result_valid} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {s_ready, busy, result_valid});
    else n_pass++;
    n_checks++;
    if ({feature_WrEn, fullyconnected_WrEn, bias_WrEn, convolution_enable} !== 4'b1111)
      $display("FAIL reset_strobes got %b want 1111",
               {feature_WrEn, fullyconnected_WrEn, bias_WrEn, convolution_enable});
    else n_pass++;
    n_checks++;
    if ({result, feature_writeAddr, fullyconnected_writeAddr} !== 15'd0)
      $display("FAIL reset_result_addr got %h want 0", {result, feature_writeAddr, fullyconnected_writeAddr});
    else n_pass++;
    n_checks++;
    if ({feature_weights_input, fullyconnected_weights_input, bias_weights_input} !== '0)
      $display("FAIL reset_data got %h want 0",
               {feature_weights_input, fullyconnected_weights_input, bias_weights_input});
    else n_pass++;
    #2 rst_cnn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_stream;
    int bad = 0;
    int a0 = acc_q.size();
    int s0 = fw_data_q.size() + fc_data_q.size() + bias_q.size() + conv_q.size();
    repeat (100) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      @(negedge clk);
      if (s_ready || busy || any_low || !convolution_enable) bad++;
    end
    s_valid = 1'b0;
    n_checks++;
    if (bad !== 0) $display("FAIL idle_flags got %0d bad cycles want 0", bad); else n_pass++;
    n_checks++;
    if (acc_q.size() - a0 !== 0) $display("FAIL idle_accept got %0d bytes want 0", acc_q.size() - a0);
    else n_pass++;
    n_checks++;
    if (fw_data_q.size() + fc_data_q.size() + bias_q.size() + conv_q.size() - s0 !== 0)
      $display("FAIL idle_strobes got %0d strobes want 0",
               fw_data_q.size() + fc_data_q.size() + bias_q.size() + conv_q.size() - s0);
    else n_pass++;
  endtask

  task automatic test_full_load;
    int fo = fw_data_q.size(), co = fc_data_q.size(), bo = bias_q.size(), c0 = conv_q.size();
    int rv0 = rv_q.size(), bf0 = busy_fall_q.size(), a0 = acc_q.size(), v0 = strobe_viol;
    int t, e;
    bit to;
    logic [FEAT_B*DW-1:0] f1;
    logic [FCC*DW-1:0]    c26;
    logic [NBIAS*BW-1:0]  bw;
    for (int i = 0; i < TOTAL; i++) stream[i] = 8'(i);
    cnn_output = 8'h5A;
    drive_stream(0);
    wait_result(rv0, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL full_timeout got no result_valid want pulse"); else n_pass++;
    for (int f = 0; f < NF; f++) begin
      t = (fw_cyc_q.size() > fo + f) ? fw_cyc_q[fo+f] : -1;
      n_checks++;
      if (t !== 17 * (f + 1)) $display("FAIL full_feat_cycle%0d got %0d want %0d", f, t, 17 * (f + 1));
      else n_pass++;
    end
    f1  = (fw_data_q.size() > fo + 1) ? fw_data_q[fo+1] : 'x;
    c26 = (fc_data_q.size() > co + 26) ? fc_data_q[co+26] : 'x;
    bw  = (bias_q.size() > bo) ? bias_q[bo] : 'x;
    n_checks++;
    if (f1[7:0] !== 8'h10) $display("FAIL full_feat1_w0 got %h want 10", f1[7:0]); else n_pass++;
    n_checks++;
    if (c26[127:120] !== 8'hDF) $display("FAIL full_fc26_w15 got %h want df", c26[127:120]); else n_pass++;
    n_checks++;
    if (bw[127:96] !== 32'hEFEEEDEC) $display("FAIL full_bias3 got %h want efeeedec", bw[127:96]);
    else n_pass++;
    e = load_errors(fo, co, bo);
    n_checks++;
    if (e !== 0) $display("FAIL full_contents got %0d errors want 0", e); else n_pass++;
    n_checks++;
    if (acc_q.size() - a0 !== TOTAL) $display("FAIL full_bytes got %0d want %0d", acc_q.size() - a0, TOTAL);
    else n_pass++;
    n_checks++;
    if (conv_q.size() - c0 !== 1) $display("FAIL full_conv_len got %0d want 1", conv_q.size() - c0);
    else n_pass++;
    n_checks++;
    if (rv_q.size() - rv0 !== 1) $display("FAIL full_rv_len got %0d want 1", rv_q.size() - rv0);
    else n_pass++;
    t = ((rv_q.size() > rv0) ? rv_q[rv0] : 0) - ((conv_q.size() > c0) ? conv_q[c0] : 0);
    n_checks++;
    if (t !== RUN + 1) $display("FAIL full_run_latency got %0d want %0d", t, RUN + 1); else n_pass++;
    n_checks++;
    if (((rv_val_q.size() > rv0) ? rv_val_q[rv0] : 8'hxx) !== 8'h5A)
      $display("FAIL full_result got %h want 5a", (rv_val_q.size() > rv0) ? rv_val_q[rv0] : 8'hxx);
    else n_pass++;
    n_checks++;
    if (result !== 8'h5A) $display("FAIL full_result_hold got %h want 5a", result); else n_pass++;
    t = ((busy_fall_q.size() > bf0) ? busy_fall_q[bf0] : 0) - ((rv_q.size() > rv0) ? rv_q[rv0] : 0);
    n_checks++;
    if (t !== 1) $display("FAIL full_busy_fall got %0d want 1", t); else n_pass++;
    n_checks++;
    if (strobe_viol - v0 !== 0) $display("FAIL full_strobe_rules got %0d want 0", strobe_viol - v0);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    int fo = fw_data_q.size(), co = fc_data_q.size(), bo = bias_q.size();
    int rv0 = rv_q.size(), a0 = acc_q.size(), v0 = strobe_viol, e, bad = 0;
    bit to;
    logic [7:0] exp_r = 8'($urandom);
    for (int i = 0; i < TOTAL; i++) stream[i] = 8'($urandom);
    cnn_output = exp_r;
    drive_stream(1);
    wait_result(rv0, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL bp_timeout got no result_valid want pulse"); else n_pass++;
    e = load_errors(fo, co, bo);
    n_checks++;
    if (e !== 0) $display("FAIL bp_contents got %0d errors want 0", e); else n_pass++;
    n_checks++;
    if (acc_q.size() - a0 !== TOTAL) $display("FAIL bp_bytes got %0d want %0d", acc_q.size() - a0, TOTAL);
    else n_pass++;
    for (int i = 0; i < TOTAL; i++) if (acc_q.size() <= a0 + i || acc_q[a0+i] !== stream[i]) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL bp_byte_order got %0d wrong want 0", bad); else n_pass++;
    n_checks++;
    if (strobe_viol - v0 !== 0) $display("FAIL bp_strobe_rules got %0d want 0", strobe_viol - v0);
    else n_pass++;
    n_checks++;
    if (((rv_val_q.size() > rv0) ? rv_val_q[rv0] : 8'hxx) !== exp_r)
      $display("FAIL bp_result got %h want %h", (rv_val_q.size() > rv0) ? rv_val_q[rv0] : 8'hxx, exp_r);
    else n_pass++;
  endtask

  task automatic test_busy_guard;
    int fo = fw_data_q.size(), co = fc_data_q.size(), bo = bias_q.size(), c0 = conv_q.size();
    int rv0 = rv_q.size(), e;
    bit to, gto;
    logic busy_at_pulse;
    logic [7:0] exp_r = 8'($urandom);
    for (int i = 0; i < TOTAL; i++) stream[i] = 8'($urandom);
    cnn_output = exp_r;
    fork
      drive_stream(2);
      begin
        int w = 0;
        while (fc_addr_q.size() < co + 5 && w < 5000) begin @(negedge clk); w++; end
        gto = (fc_addr_q.size() < co + 5);
        @(posedge clk); #2;
        load_start = 1'b1;
        @(negedge clk);
        busy_at_pulse = busy;
        @(posedge clk); #2;
        load_start = 1'b0;
      end
    join
    wait_result(rv0, to);
    n_checks++;
    if (gto !== 1'b0 || busy_at_pulse !== 1'b1)
      $display("FAIL guard_pulse_in_fc got timeout=%0b busy=%b want 0/1", gto, busy_at_pulse);
    else n_pass++;
    n_checks++;
    if (to !== 1'b0) $display("FAIL guard_timeout got no result_valid want pulse"); else n_pass++;
    e = load_errors(fo, co, bo);
    n_checks++;
    if (e !== 0) $display("FAIL guard_contents got %0d errors want 0", e); else n_pass++;
    n_checks++;
    if (conv_q.size() - c0 !== 1) $display("FAIL guard_conv got %0d want 1", conv_q.size() - c0);
    else n_pass++;
    n_checks++;
    if (((rv_val_q.size() > rv0) ? rv_val_q[rv0] : 8'hxx) !== exp_r)
      $display("FAIL guard_result got %h want %h", (rv_val_q.size() > rv0) ? rv_val_q[rv0] : 8'hxx, exp_r);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fc;
    int co = fc_data_q.size(), fo, bo, rv0, e, t;
    bit to, wto;
    for (int i = 0; i < TOTAL; i++) stream[i] = 8'(i);
    abort = 1'b0;
    fork
      drive_stream(0);
      begin
        int w = 0;
        while (fc_addr_q.size() < co + 11 && w < 5000) begin @(negedge clk); w++; end
        wto = (fc_addr_q.size() < co + 11);
        @(posedge clk); #3;
        rst_cnn = 1'b0;
        #1;
        n_checks++;
        if (wto !== 1'b0 || {feature_WrEn, fullyconnected_WrEn, bias_WrEn, convolution_enable} !== 4'b1111)
          $display("FAIL rstmid_strobes got timeout=%0b strobes=%b want 0/1111", wto,
                   {feature_WrEn, fullyconnected_WrEn, bias_WrEn, convolution_enable});
        else n_pass++;
        n_checks++;
        if ({busy, s_ready} !== 2'b00) $display("FAIL rstmid_busy got %b want 00", {busy, s_ready});
        else n_pass++;
        n_checks++;
        if (fullyconnected_writeAddr !== 5'd0)
          $display("FAIL rstmid_fc_addr got %0d want 0", fullyconnected_writeAddr);
        else n_pass++;
        abort = 1'b1;
      end
    join
    @(negedge clk); #2;
    rst_cnn = 1'b1;
    abort   = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fc_addr_q.size() - co !== 11) $display("FAIL rstmid_fc_count got %0d want 11", fc_addr_q.size() - co);
    else n_pass++;
    fo = fw_data_q.size(); co = fc_data_q.size(); bo = bias_q.size(); rv0 = rv_q.size();
    cnn_output = 8'hC3;
    drive_stream(0);
    wait_result(rv0, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL reload_timeout got no result_valid want pulse"); else n_pass++;
    n_checks++;
    if (((fw_addr_q.size() > fo) ? fw_addr_q[fo] : -1) !== 0)
      $display("FAIL reload_first_addr got %0d want 0", (fw_addr_q.size() > fo) ? fw_addr_q[fo] : -1);
    else n_pass++;
    t = (fw_cyc_q.size() > fo) ? fw_cyc_q[fo] : -1;
    n_checks++;
    if (t !== 17) $display("FAIL reload_first_cycle got %0d want 17", t); else n_pass++;
    e = load_errors(fo, co, bo);
    n_checks++;
    if (e !== 0) $display("FAIL reload_contents got %0d errors want 0", e); else n_pass++;
    n_checks++;
    if (((rv_val_q.size() > rv0) ? rv_val_q[rv0] : 8'hxx) !== 8'hC3)
      $display("FAIL reload_result got %h want c3", (rv_val_q.size() > rv0) ? rv_val_q[rv0] : 8'hxx);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_idle_stream;
    test_full_load;
    test_backpressure;
    test_busy_guard;
    test_reset_mid_fc;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cnn_param_loader.md
Name: cnn_param_loader

Overview:
- Host-side sequencer that drives the CNN core's weight-memory write ports and start input.
- Accepts a byte stream over a valid/ready handshake, packs it into feature, fully-connected and bias write transactions, and issues each as a one-cycle active-low write strobe.
- After loading, pulses convolution_enable (active-low), waits a fixed run time, then captures cnn_output.
- Sits between the chip's host interface and the CNN core.

Parameters:
- KERNEL_SIZE, 4, kernel edge; feature chunk = KERNEL_SIZE*KERNEL_SIZE = 16 bytes.
- NUM_FEATURES, 3, number of conv features / bias words minus one.
- FLATTENED_LENGTH, 432, FC weight count; must be a multiple of FC_CHUNK.
- FC_CHUNK, 16, FC weights per write.
- DATA_WIDTH, 8, weight and stream byte width.
- BIAS_DATA_WIDTH, 32, bias word width; must be a multiple of 8.
- RUN_CYCLES, 640, clk cycles from start strobe to cnn_output capture; must be ≥ 631.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_cnn  in  1  reset, asynchronous, active-low.
- load_start  in  1  active-high request to begin a load+run sequence.
- s_valid  in  1  stream byte valid.
- s_data  in  8  stream byte.
- s_ready  out  1  loader can accept a byte.
- feature_weights_input  out  8 x 16 signed  packed feature kernel.
- feature_writeAddr  out  2  feature index.
- feature_WrEn  out  1  active-low feature write strobe.
- fullyconnected_weights_input  out  8 x 16 signed  FC chunk.
- fullyconnected_writeAddr  out  5  FC chunk index, 0..26.
- fullyconnected_WrEn  out  1  active-low FC write strobe.
- bias_weights_input  out  32 x 4 signed  all biases.
- bias_WrEn  out  1  active-low bias write strobe.
- convolution_enable  out  1  active-low CNN start.
- cnn_output  in  8  CNN result.
- result  out  8  captured cnn_output.
- result_valid  out  1  one-cycle pulse when result updates.
- busy  out  1  high from load_start acceptance until DONE exits.

Behaviour:
- Reset values:
  - s_ready=0, busy=0, result_valid=0.
  - All WrEn=1, convolution_enable=1.
  - result=0, data/addr outputs=0.
  - All counters=0, state=IDLE.
- Stream order, 496 bytes total:
  - 48 feature bytes: feature f weight k at stream index f*16+k.
  - 432 FC bytes in weight order.
  - 16 bias bytes: bias b little-endian, byte j at index 480+4b+j; index NUM_FEATURES is the FC bias.
- A byte transfers on a posedge with s_valid&s_ready. s_ready is 1 only in LOAD_* states.
- FSM states and transitions:
  - IDLE: busy=0. On load_start=1 → LOAD_FEAT, busy=1.
  - LOAD_FEAT: shift bytes into the 16-entry buffer at element index byte_cnt. At the 16th byte → WR_FEAT.
  - WR_FEAT (1 cycle): s_ready=0, feature_WrEn=0, feature_writeAddr=feat_idx, data stable. Next: feat_idx+1; → LOAD_FEAT, or → LOAD_FC after feature NUM_FEATURES-1.
  - LOAD_FC / WR_FC: same pattern with fullyconnected_WrEn and fullyconnected_writeAddr=chunk_idx. After chunk 26 → LOAD_BIAS.
  - LOAD_BIAS: collect 16 bytes → WR_BIAS (1 cycle, bias_WrEn=0) → START.
  - START (1 cycle): convolution_enable=0; run counter cleared → RUN.
  - RUN: count RUN_CYCLES cycles, then → DONE.
  - DONE (1 cycle): result<=cnn_output, result_valid=1 → IDLE.
- Data and address outputs hold their last value outside write cycles. Only one WrEn is low at any time, and never two cycles in a row.
- Gaps in s_valid stall the FSM with no timeout; counters hold.
- load_start while busy=1 is ignored. load_start and s_valid in the same IDLE cycle: the byte is not accepted (s_ready=0 in IDLE).
- Asynchronous reset mid-sequence:
  - All strobes deassert immediately and state returns to IDLE.
  - Partially loaded memories are not rolled back; the host must reload in full.
- Width rules: bytes pass through as two's-complement signed, with no arithmetic. Bias words are concatenated bytes, with no sign extension needed.

Test Plan:
- Full load: byte i = i[7:0], s_valid constant.
  - Expect feature writes at cycles 17/34/51 with addr 0,1,2; feature 1 weight 0 = 0x10.
  - Expect 27 FC writes; chunk 26 weight 15 = 0xDF.
  - Expect one bias write with bias[3] = 0xEFEEEDEC.
  - Expect convolution_enable low exactly 1 cycle; result_valid RUN_CYCLES+1 cycles later.
- Backpressure: s_valid toggling 1/0 every cycle → same write contents as the full-load test, byte count 496, s_ready=0 on every WrEn cycle.
- Result capture: cnn_output held at 0x5A during RUN → result=0x5A and result_valid high for exactly 1 cycle; busy falls the following cycle.
- Busy guard: load_start pulsed during LOAD_FC → no restart; chunk addresses continue monotonically 0..26.
- Reset mid-FC: rst_cnn low after FC chunk 10 → all WrEn=1, convolution_enable=1, busy=0 asynchronously.
  - New load_start then restarts at feature_writeAddr=0.
- Idle stream: s_valid=1 with no load_start for 100 cycles → s_ready=0, no strobes, busy=0.
